// File: rtl/cruise_setpoint_controller.sv
// Cruise-control set-point controller: decides when the downstream 8-bit
// set-speed register loads and what value it takes. Tracks the driver
// controls with a 4-state FSM and maintains the target speed with saturation
// and press-and-hold auto-repeat for accel/decel.
module cruise_setpoint_controller #(
    parameter int unsigned STEP          = 2,
    parameter int unsigned MIN_SPEED     = 40,
    parameter int unsigned MAX_SPEED     = 200,
    parameter int unsigned HOLD_CYCLES   = 50,
    parameter int unsigned REPEAT_CYCLES = 10
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] speed,
    input  logic       cruise_on,
    input  logic       set_btn,
    input  logic       resume_btn,
    input  logic       accel_btn,
    input  logic       decel_btn,
    input  logic       brake,
    output logic [7:0] reg_data,
    output logic       reg_load,
    output logic       active,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'b00,
        ST_STANDBY   = 2'b01,
        ST_CRUISE    = 2'b10,
        ST_SUSPENDED = 2'b11
    } state_t;

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    localparam logic [7:0]    STEP8  = 8'(STEP);
    localparam logic [8:0]    STEP9  = 9'(STEP);
    localparam logic [7:0]    MIN8   = 8'(MIN_SPEED);
    localparam logic [8:0]    MIN9   = 9'(MIN_SPEED);
    localparam logic [7:0]    MAX8   = 8'(MAX_SPEED);
    localparam logic [8:0]    MAX9   = 9'(MAX_SPEED);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
    // After a repeat step the counter is rewound so it reaches HOLD_C again
    // exactly REPEAT_CYCLES later.
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - REPEAT_CYCLES + 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    state_t        state_q, state_d;
    logic [7:0]    target_q, target_d;
    logic          load_q, load_d;
    logic          active_q, active_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [CW-1:0] dec_cnt_q, dec_cnt_d;
    logic          set_prev_q, set_prev_d;
    logic          res_prev_q, res_prev_d;
    logic          acc_prev_q, acc_prev_d;
    logic          dec_prev_q, dec_prev_d;

    logic       set_edge, res_edge, acc_edge, dec_edge;
    logic       speed_ok, hold_ok, acc_only, dec_only;
    logic       acc_fire, dec_fire;
    logic [8:0] up_sum;
    logic [7:0] up_val, dn_val;

    assign set_edge = set_btn    & ~set_prev_q;
    assign res_edge = resume_btn & ~res_prev_q;
    assign acc_edge = accel_btn  & ~acc_prev_q;
    assign dec_edge = decel_btn  & ~dec_prev_q;

    assign speed_ok = (speed >= MIN8) && (speed <= MAX8);
    assign hold_ok  = (state_q == ST_CRUISE) && cruise_on && !brake;
    assign acc_only = accel_btn & ~decel_btn;
    assign dec_only = decel_btn & ~accel_btn;

    // Step arithmetic is 9-bit so an overflow past 255 still clamps to MAX.
    assign up_sum = {1'b0, target_q} + STEP9;
    assign up_val = (up_sum > MAX9) ? MAX8 : up_sum[7:0];
    assign dn_val = ({1'b0, target_q} >= (MIN9 + STEP9)) ? (target_q - STEP8) : MIN8;

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= ST_OFF;
            target_q   <= '0;
            load_q     <= 1'b0;
            active_q   <= 1'b0;
            acc_cnt_q  <= '0;
            dec_cnt_q  <= '0;
            set_prev_q <= 1'b0;
            res_prev_q <= 1'b0;
            acc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            load_q     <= load_d;
            active_q   <= active_d;
            acc_cnt_q  <= acc_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            set_prev_q <= set_prev_d;
            res_prev_q <= res_prev_d;
            acc_prev_q <= acc_prev_d;
            dec_prev_q <= dec_prev_d;
        end
    end

    // Next-state logic: !cruise_on > brake > set edge > resume edge.
    always_comb begin
        state_d = state_q;
        if (!cruise_on) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:       state_d = ST_STANDBY;
                ST_STANDBY:   if (!brake && set_edge && speed_ok) state_d = ST_CRUISE;
                ST_CRUISE:    if (brake) state_d = ST_SUSPENDED;
                ST_SUSPENDED: if (!brake && ((set_edge && speed_ok) || res_edge)) state_d = ST_CRUISE;
                default:      state_d = ST_OFF;
            endcase
        end
    end

    // Hold counters: count held cycles since a press edge while in CRUISE;
    // a step fires on the edge and each time the counter reaches HOLD_C.
    always_comb begin
        acc_cnt_d = '0;
        dec_cnt_d = '0;
        acc_fire  = 1'b0;
        dec_fire  = 1'b0;
        if (hold_ok && acc_only) begin
            if (acc_edge) begin
                acc_cnt_d = ONE_C;
                acc_fire  = 1'b1;
            end else if (acc_cnt_q == HOLD_C) begin
                acc_cnt_d = RELOAD;
                acc_fire  = 1'b1;
            end else if (acc_cnt_q != '0) begin
                acc_cnt_d = acc_cnt_q + ONE_C;
            end
        end
        if (hold_ok && dec_only) begin
            if (dec_edge) begin
                dec_cnt_d = ONE_C;
                dec_fire  = 1'b1;
            end else if (dec_cnt_q == HOLD_C) begin
                dec_cnt_d = RELOAD;
                dec_fire  = 1'b1;
            end else if (dec_cnt_q != '0) begin
                dec_cnt_d = dec_cnt_q + ONE_C;
            end
        end
    end

    // Output logic: target update, load strobe, active flag, edge history.
    always_comb begin
        target_d   = target_q;
        load_d     = 1'b0;
        set_prev_d = set_btn;
        res_prev_d = resume_btn;
        acc_prev_d = accel_btn;
        dec_prev_d = decel_btn;
        if (!cruise_on) begin
            target_d = '0;
            load_d   = (target_q != '0);
        end else if (!brake) begin
            case (state_q)
                ST_STANDBY: begin
                    if (set_edge && speed_ok) begin
                        target_d = speed;
                        load_d   = 1'b1;
                    end
                end
                ST_CRUISE: begin
                    // An accepted set is an explicit capture and always loads;
                    // steps load only when the clamped value differs.
                    if (set_edge && speed_ok) begin
                        target_d = speed;
                        load_d   = 1'b1;
                    end else if (acc_fire) begin
                        target_d = up_val;
                        load_d   = (up_val != target_q);
                    end else if (dec_fire) begin
                        target_d = dn_val;
                        load_d   = (dn_val != target_q);
                    end
                end
                ST_SUSPENDED: begin
                    if (set_edge && speed_ok) begin
                        target_d = speed;
                        load_d   = 1'b1;
                    end else if (res_edge) begin
                        load_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        active_d = (state_d == ST_CRUISE);
    end

    assign reg_data = target_q;
    assign reg_load = load_q;
    assign active   = active_q;
    assign state    = state_q;

endmodule
